// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer, the PC register and decode.
// Width defaults live here so all three stages agree on them.
package pc_fetch_sequencer_pkg;

  localparam int unsigned CONTENT_SIZE = 16;
  localparam int unsigned INSTR_SIZE   = 32;
  localparam int unsigned PC_STEP      = 1;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StHold = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side signal bundle: PC register, instruction memory, decode, redirect and halt.
// The master modport is the sequencer; the slave modport is the surrounding core.
interface pc_fetch_sequencer_if
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned ContentSize = CONTENT_SIZE,
  parameter int unsigned InstrSize   = INSTR_SIZE
) ();

  logic [ContentSize-1:0] i_pc;
  logic [ContentSize-1:0] o_pc_next;
  logic                   o_pc_en;
  logic                   o_imem_req;
  logic [ContentSize-1:0] o_imem_addr;
  logic                   i_imem_ack;
  logic [InstrSize-1:0]   i_imem_data;
  logic [InstrSize-1:0]   o_instr;
  logic                   o_instr_valid;
  logic                   i_instr_ready;
  logic                   i_redirect;
  logic [ContentSize-1:0] i_redirect_target;
  logic                   i_halt;
  logic                   o_halted;

  modport master (
    input  i_pc,
    output o_pc_next,
    output o_pc_en,
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_data,
    output o_instr,
    output o_instr_valid,
    input  i_instr_ready,
    input  i_redirect,
    input  i_redirect_target,
    input  i_halt,
    output o_halted
  );

  modport slave (
    output i_pc,
    input  o_pc_next,
    input  o_pc_en,
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_data,
    input  o_instr,
    input  o_instr_valid,
    output i_instr_ready,
    output i_redirect,
    output i_redirect_target,
    output i_halt,
    input  o_halted
  );

endinterface

// File: rtl/pc_fetch_sequencer_fetch_buf.sv
// Single-entry instruction holding register.
// Priority: reset > clear > load. A clear drops the entry but leaves the data bits in place.
module pc_fetch_sequencer_fetch_buf #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: drives the PC register's next value and enable, issues one
// instruction-memory read at a time and holds the returned word until decode takes it.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned ContentSize = CONTENT_SIZE,
  parameter int unsigned InstrSize   = INSTR_SIZE,
  parameter int unsigned PcStep      = PC_STEP
) (
  input logic                  clk,
  input logic                  rst,
  pc_fetch_sequencer_if.master fetch_io
);

  fetch_state_e state_q, state_d;
  logic         halted_q, halted_d;
  logic         buf_load, buf_clear;

  logic [ContentSize-1:0] pc_inc;
  assign pc_inc = fetch_io.i_pc + ContentSize'(PcStep);

  always_comb begin
    state_d             = state_q;
    buf_load            = 1'b0;
    buf_clear           = 1'b0;
    fetch_io.o_pc_en    = 1'b0;
    fetch_io.o_pc_next  = fetch_io.i_pc;
    fetch_io.o_imem_req = 1'b0;

    if (rst) begin
      state_d            = StReq;
      buf_clear          = 1'b1;
      fetch_io.o_pc_next = '0;
    end else begin
      unique case (state_q)
        StReq: begin
          fetch_io.o_imem_req = 1'b1;
          // Redirect discards any ack landing on the stale address.
          if (fetch_io.i_redirect) begin
            fetch_io.o_pc_en   = 1'b1;
            fetch_io.o_pc_next = fetch_io.i_redirect_target;
          end else if (fetch_io.i_halt) begin
            fetch_io.o_imem_req = 1'b0;
            state_d             = StHalt;
          end else if (fetch_io.i_imem_ack) begin
            buf_load = 1'b1;
            state_d  = StHold;
          end
        end
        StHold: begin
          if (fetch_io.i_redirect) begin
            fetch_io.o_pc_en   = 1'b1;
            fetch_io.o_pc_next = fetch_io.i_redirect_target;
            buf_clear          = 1'b1;
            state_d            = StReq;
          end else if (fetch_io.i_instr_ready) begin
            // Halt is only honoured once the held instruction has been consumed.
            fetch_io.o_pc_en   = 1'b1;
            fetch_io.o_pc_next = pc_inc;
            buf_clear          = 1'b1;
            state_d            = fetch_io.i_halt ? StHalt : StReq;
          end
        end
        StHalt: begin
          if (fetch_io.i_redirect) begin
            fetch_io.o_pc_en   = 1'b1;
            fetch_io.o_pc_next = fetch_io.i_redirect_target;
          end
          if (!fetch_io.i_halt) begin
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  assign halted_d = (state_d == StHalt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReq;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  pc_fetch_sequencer_fetch_buf #(
    .Width (InstrSize)
  ) u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (fetch_io.i_imem_data),
    .data_o  (fetch_io.o_instr),
    .valid_o (fetch_io.o_instr_valid)
  );

  assign fetch_io.o_imem_addr = fetch_io.i_pc;
  assign fetch_io.o_halted    = halted_q;

  a_halt_no_req: assert property (@(posedge clk) disable iff (rst)
    halted_q |-> !fetch_io.o_imem_req);
  a_halt_no_valid: assert property (@(posedge clk) disable iff (rst)
    halted_q |-> !fetch_io.o_instr_valid);
  a_req_no_valid: assert property (@(posedge clk) disable iff (rst)
    fetch_io.o_imem_req |-> !fetch_io.o_instr_valid);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a directed cycle table, then randomized traffic
// checked against a transaction-level model of the fetch rules.
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  localparam int unsigned CW = CONTENT_SIZE;
  localparam int unsigned IW = INSTR_SIZE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.ContentSize(CW), .InstrSize(IW)) bus ();

  pc_fetch_sequencer #(
    .ContentSize (CW),
    .InstrSize   (IW),
    .PcStep      (PC_STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_io (bus)
  );

  function automatic logic [IW-1:0] mem_word(input logic [CW-1:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  // PC register outside the DUT, and a zero-latency memory image.
  logic [CW-1:0] pc_q;
  always @(posedge clk) begin
    if (rst) pc_q <= '0;
    else if (bus.o_pc_en) pc_q <= bus.o_pc_next;
  end
  assign bus.i_pc        = pc_q;
  assign bus.i_imem_data = mem_word(pc_q);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          redir;
    logic [CW-1:0] tgt;
    logic          halt;
    logic          ack;
    logic          ready;
    logic [CW-1:0] exp_pc;
    logic          exp_req;
    logic          exp_en;
    logic [CW-1:0] exp_next;
    logic          exp_valid;
    logic          exp_halted;
    logic [CW-1:0] exp_iaddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [CW-1:0] t,
                              input logic h, input logic a, input logic rdy,
                              input logic [CW-1:0] p, input logic rq, input logic en,
                              input logic [CW-1:0] nx, input logic v, input logic hl,
                              input logic [CW-1:0] ia);
    vec_t x;
    x.rst = r; x.redir = rd; x.tgt = t; x.halt = h; x.ack = a; x.ready = rdy;
    x.exp_pc = p; x.exp_req = rq; x.exp_en = en; x.exp_next = nx;
    x.exp_valid = v; x.exp_halted = hl; x.exp_iaddr = ia;
    return x;
  endfunction

  task automatic drive(input logic r, input logic rd, input logic [CW-1:0] t,
                       input logic h, input logic a, input logic rdy);
    rst                   = r;
    bus.i_redirect        = rd;
    bus.i_redirect_target = t;
    bus.i_halt            = h;
    bus.i_imem_ack        = a;
    bus.i_instr_ready     = rdy;
  endtask

  vec_t vecs[$];

  // Reference model: "holding" and "halted" flags plus the held word.
  bit            m_buf, m_halt;
  logic [IW-1:0] m_instr;

  initial begin
    logic          e_req, e_en, n_buf, n_halt, halt_lvl;
    logic [CW-1:0] e_next;
    logic [IW-1:0] n_instr;
    logic          r_rst, r_redir, r_ack, r_ready;
    logic [CW-1:0] r_tgt;

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset req", bus.o_imem_req, 0);
    chk("reset pc_en", bus.o_pc_en, 0);
    chk("reset pc_next", bus.o_pc_next, 0);
    @(posedge clk); #1;
    chk("reset valid", bus.o_instr_valid, 0);
    chk("reset halted", bus.o_halted, 0);
    chk("reset instr", bus.o_instr, 0);
    chk("reset pc", pc_q, 0);

    // rst redir tgt halt ack ready | pc req en next | valid halted iaddr
    vecs.push_back(mk(0,0,16'h0000,0,1,1, 16'h0000,1,0,16'h0000, 1,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000,0,1,16'h0001, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,1, 16'h0001,1,0,16'h0001, 1,0,16'h0001));
    vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0001,0,1,16'h0002, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,1, 16'h0002,1,0,16'h0002, 1,0,16'h0002));
    vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0002,0,1,16'h0003, 0,0,16'h0000));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,16'h0000,0,0,0, 16'h0003,1,0,16'h0003, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0003,1,0,16'h0003, 1,0,16'h0003));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,16'h0000,0,0,0, 16'h0003,0,0,16'h0003, 1,0,16'h0003));
    vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0003,0,1,16'h0004, 0,0,16'h0000));
    vecs.push_back(mk(0,1,16'h0040,0,1,0, 16'h0004,1,1,16'h0040, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0040,1,0,16'h0040, 1,0,16'h0040));
    vecs.push_back(mk(0,1,16'h0040,0,0,1, 16'h0040,0,1,16'h0040, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0040,1,0,16'h0040, 1,0,16'h0040));
    vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0040,0,0,16'h0040, 1,0,16'h0040));
    vecs.push_back(mk(0,0,16'h0000,1,0,1, 16'h0040,0,1,16'h0041, 0,1,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1,1,0, 16'h0041,0,0,16'h0041, 0,1,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,0,0, 16'h0041,0,0,16'h0041, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,1, 16'h0041,1,0,16'h0041, 1,0,16'h0041));
    vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0041,0,1,16'h0042, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1,1,0, 16'h0042,0,0,16'h0042, 0,1,16'h0000));
    vecs.push_back(mk(0,1,16'hFFFF,1,0,0, 16'h0042,0,1,16'hFFFF, 0,1,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,0,0, 16'hFFFF,0,0,16'hFFFF, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'hFFFF,1,0,16'hFFFF, 1,0,16'hFFFF));
    vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'hFFFF,0,1,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(0,1,16'h0007,0,0,0, 16'h0000,1,1,16'h0007, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0007,1,0,16'h0007, 1,0,16'h0007));
    vecs.push_back(mk(1,1,16'h0055,0,0,1, 16'h0007,0,0,16'h0000, 0,0,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0000,1,0,16'h0000, 1,0,16'h0000));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].redir, vecs[i].tgt, vecs[i].halt, vecs[i].ack, vecs[i].ready);
      #1;
      chk($sformatf("row%0d pc", i), pc_q, vecs[i].exp_pc);
      chk($sformatf("row%0d imem_addr", i), bus.o_imem_addr, vecs[i].exp_pc);
      chk($sformatf("row%0d req", i), bus.o_imem_req, vecs[i].exp_req);
      chk($sformatf("row%0d pc_en", i), bus.o_pc_en, vecs[i].exp_en);
      chk($sformatf("row%0d pc_next", i), bus.o_pc_next, vecs[i].exp_next);
      @(posedge clk); #1;
      chk($sformatf("row%0d valid", i), bus.o_instr_valid, vecs[i].exp_valid);
      chk($sformatf("row%0d halted", i), bus.o_halted, vecs[i].exp_halted);
      if (vecs[i].exp_valid)
        chk($sformatf("row%0d instr", i), bus.o_instr, mem_word(vecs[i].exp_iaddr));
    end

    // Randomized traffic, starting from a reset so the model is in step.
    @(negedge clk);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    m_buf = 0; m_halt = 0; m_instr = '0;
    halt_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r_rst   = ($urandom_range(0, 99) < 2);
      r_redir = ($urandom_range(0, 9) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : CW'($urandom);
      if ($urandom_range(0, 9) == 0) halt_lvl = ~halt_lvl;
      r_ack   = $urandom_range(0, 1) == 1;
      r_ready = $urandom_range(0, 1) == 1;
      drive(r_rst, r_redir, r_tgt, halt_lvl, r_ack, r_ready);
      #1;
      e_req = 0; e_en = 0; e_next = pc_q;
      n_buf = m_buf; n_halt = m_halt; n_instr = m_instr;
      if (r_rst) begin
        e_next = '0; n_buf = 0; n_halt = 0; n_instr = '0;
      end else if (m_halt) begin
        if (r_redir) begin e_en = 1; e_next = r_tgt; end
        n_halt = halt_lvl;
      end else if (m_buf) begin
        if (r_redir) begin
          e_en = 1; e_next = r_tgt; n_buf = 0;
        end else if (r_ready) begin
          e_en = 1; e_next = pc_q + CW'(PC_STEP); n_buf = 0; n_halt = halt_lvl;
        end
      end else begin
        e_req = !(halt_lvl && !r_redir);
        if (r_redir) begin
          e_en = 1; e_next = r_tgt;
        end else if (halt_lvl) begin
          n_halt = 1;
        end else if (r_ack) begin
          n_buf = 1; n_instr = mem_word(pc_q);
        end
      end
      chk($sformatf("rnd%0d req", c), bus.o_imem_req, e_req);
      chk($sformatf("rnd%0d pc_en", c), bus.o_pc_en, e_en);
      chk($sformatf("rnd%0d pc_next", c), bus.o_pc_next, e_next);
      @(posedge clk); #1;
      m_buf = n_buf; m_halt = n_halt; m_instr = n_instr;
      chk($sformatf("rnd%0d valid", c), bus.o_instr_valid, m_buf);
      chk($sformatf("rnd%0d halted", c), bus.o_halted, m_halt);
      if (m_buf || r_rst)
        chk($sformatf("rnd%0d instr", c), bus.o_instr, m_instr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Fetch controller that sequences the program counter register: it produces the PC register's next-value and enable inputs, issues instruction-memory reads at the current PC, and buffers one fetched instruction for decode.
- Handles sequential advance, branch/jump redirect from execute, and halt.
- Sits between the PC register, instruction memory and the decode stage of the MIPS-style core.

Parameters:
- CONTENT_SIZE, 16, PC/address width (must match the PC register).
- INSTR_SIZE, 32, instruction word width.
- PC_STEP, 1, PC increment per instruction (word-addressed memory).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_pc  input  CONTENT_SIZE  current value of the PC register.
- o_pc_next  output  CONTENT_SIZE  next-value input to the PC register.
- o_pc_en  output  1  PC register enable; PC loads o_pc_next on this clock edge.
- o_imem_req  output  1  instruction read request.
- o_imem_addr  output  CONTENT_SIZE  read address, always equal to i_pc.
- i_imem_ack  input  1  read data valid for the address presented this cycle; only meaningful while o_imem_req=1.
- i_imem_data  input  INSTR_SIZE  read data.
- o_instr  output  INSTR_SIZE  buffered instruction to decode.
- o_instr_valid  output  1  o_instr is valid.
- i_instr_ready  input  1  decode accepts o_instr this cycle.
- i_redirect  input  1  taken branch or jump; level, single-cycle pulse per event.
- i_redirect_target  input  CONTENT_SIZE  redirect address.
- i_halt  input  1  halt request; level-sensitive.
- o_halted  output  1  sequencer is in S_HALT.

Behaviour:
- Reset: rst dominates every other input.
  - While rst=1: state=S_REQ, o_instr=0, o_instr_valid=0, o_pc_en=0, o_imem_req=0, o_halted=0, o_pc_next=0.
  - The PC register resets to 0 in the same cycle, so the first fetch after reset deasserts is address 0.
  - Reset mid-fetch or mid-hold discards everything.
- States: S_REQ, S_HOLD, S_HALT.
- Register vs. combinational outputs:
  - o_instr, o_instr_valid and o_halted are registered.
  - o_imem_req, o_pc_en and o_pc_next are combinational from state and inputs.
- S_REQ:
  - o_imem_req=1.
  - Priority: redirect > halt > ack.
  - i_redirect=1: o_pc_en=1, o_pc_next=target; any ack this cycle is discarded; stay in S_REQ. The new address is presented next cycle.
  - Else i_halt=1: o_imem_req forced 0; go to S_HALT.
  - Else i_imem_ack=1: latch i_imem_data into o_instr; o_instr_valid=1 from the next cycle; go to S_HOLD.
  - Best-case latency: ack at cycle t gives valid at t+1.
- S_HOLD:
  - o_imem_req=0; o_instr stable.
  - i_redirect=1 takes priority over ready: o_pc_en=1, o_pc_next=target; drop the buffer (valid=0 next cycle); go to S_REQ. A simultaneous ready is ignored.
  - Else i_instr_ready=1: handshake completes.
    - o_pc_en=1, o_pc_next=(i_pc+PC_STEP) mod 2^CONTENT_SIZE; wraps from all-ones to 0.
    - valid=0 next cycle.
    - Go to S_HALT if i_halt=1, else S_REQ.
  - Else stay. Halt never drops a buffered instruction.
- S_HALT:
  - o_imem_req=0, o_instr_valid=0, o_halted=1.
  - i_redirect=1: o_pc_en=1, o_pc_next=target; stay in S_HALT while i_halt=1.
  - i_halt=0: go to S_REQ.
- o_pc_en=0 in every case not listed above, with o_pc_next=i_pc so the PC holds.
- o_pc_en is asserted at most once per cycle; there is no lookahead or prefetch, and at most one instruction is outstanding.
- Throughput: 1 instruction per 2 cycles with zero-wait memory and always-ready decode.

Decomposition:
- Shared package/header holds:
  - state encodings S_REQ=2'd0, S_HOLD=2'd1, S_HALT=2'd2;
  - CONTENT_SIZE, INSTR_SIZE and PC_STEP defaults, shared with the PC register and decode.
- One natural sub-module: fetch_buf, a single-entry instruction holding register with load, clear and valid. The FSM and next-PC mux stay in the top level.

Test Plan:
- Reset, then zero-wait memory with ready=1:
  - required: request at i_pc=0; ack gives valid next cycle with o_instr equal to the memory word;
  - PC sequence 0,1,2,3 with o_pc_en pulsing every 2nd cycle.
- Memory acks after 3 wait cycles, and decode holds ready=0 for 4 cycles:
  - required: o_imem_req held through the wait, o_instr stable, o_pc_en=0 throughout;
  - PC increments exactly once, on the ready cycle.
- Redirect to 16'h0040:
  - in S_REQ with simultaneous ack: data discarded, next request at 0x0040;
  - in S_HOLD with simultaneous ready: buffer dropped, no PC+1, PC=0x0040.
- i_halt=1 while in S_HOLD with ready=0:
  - required: instruction still delivered on ready, then o_halted=1 and no requests;
  - halt=0 resumes fetching at PC+1.
- i_pc=16'hFFFF handshake: required o_pc_next=16'h0000.
- rst asserted in S_HOLD with valid=1: required valid=0 and S_REQ next cycle, and the first fetch after reset is at address 0.
